// File: rtl/iperm_kp_sched.sv
// Command scheduler: buffers {opcode, beat count} commands and replays each as a held kp_req/k_ctrl burst.
// Latency: command pushed into an idle, empty block is popped next cycle; kp_req rises the cycle after that.
// Backpressure: kp_req/k_ctrl hold until kp_ack; cmd_ack drops when the FIFO is full or a flush is pending.
module iperm_kp_sched #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_req,
    input  logic [3:0]                 cmd_op,
    input  logic [CW-1:0]              cmd_cnt,
    output logic                       cmd_ack,
    output logic                       kp_req,
    input  logic                       kp_ack,
    output logic [3:0]                 k_ctrl,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       err_invalid,
    input  logic                       err_clr,
    output logic [31:0]                beat_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            flush_pend_q, flush_pend_d;
    logic            flush_done_q, flush_done_d;
    logic            err_q, err_d;
    logic [31:0]     beat_cnt_q, beat_cnt_d;

    logic [3:0]      mem_op_q  [DEPTH];
    logic [3:0]      mem_op_d  [DEPTH];
    logic [CW-1:0]   mem_cnt_q [DEPTH];
    logic [CW-1:0]   mem_cnt_d [DEPTH];

    logic            full;
    logic            empty;
    logic            xfer;
    logic            last_beat;
    logic            push;
    logic            pop;
    logic            flush_apply;
    logic            err_set;
    logic [3:0]      head_op;
    logic [CW-1:0]   head_cnt;

    // Status and handshake terms, all derived from registered state
    always_comb begin
        full        = (level_q == LEVEL_FULL);
        empty       = (level_q == '0);
        kp_req      = (state_q == ISSUE);
        k_ctrl      = kp_req ? op_q : 4'd0;
        xfer        = kp_req & kp_ack;
        last_beat   = xfer & (rem_q == CW'(1));
        cmd_ack     = ~reset & ~full & ~flush & ~flush_pend_q;
        push        = cmd_req & cmd_ack;
        flush_apply = flush_pend_q & ((state_q == IDLE) | xfer);
        head_op     = mem_op_q[rd_ptr_q];
        head_cnt    = mem_cnt_q[rd_ptr_q];
        // A flush takes precedence over loading the next command
        pop         = ~flush_apply & ~empty & ((state_q == IDLE) | last_beat);
        err_set     = pop & ~((head_op == 4'd1) | (head_op == 4'd5) | (head_op == 4'd7));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d  = head_op;
                    rem_d = head_cnt;
                    if (head_cnt != '0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (xfer) begin
                    rem_d = rem_q - CW'(1);
                    if (last_beat) begin
                        if (pop) begin
                            // Back-to-back chaining keeps kp_req high with no bubble
                            op_d    = head_op;
                            rem_d   = head_cnt;
                            state_d = (head_cnt != '0) ? ISSUE : IDLE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_apply) begin
            state_d = IDLE;
            rem_d   = '0;
        end
    end

    always_comb begin
        mem_op_d  = mem_op_q;
        mem_cnt_d = mem_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;

        if (push) begin
            mem_op_d[wr_ptr_q]  = cmd_op;
            mem_cnt_d[wr_ptr_q] = cmd_cnt;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (flush_apply) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_comb begin
        flush_pend_d = flush_apply ? 1'b0 : (flush_pend_q | flush);
        flush_done_d = flush_apply;
        err_d        = err_set | (err_q & ~err_clr);
        beat_cnt_d   = beat_cnt_q;
        if (xfer) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            err_q        <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rem_q        <= rem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
            err_q        <= err_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Command storage is data-only; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        mem_op_q  <= mem_op_d;
        mem_cnt_q <= mem_cnt_d;
    end

    always_comb begin
        flush_done  = flush_done_q;
        busy        = kp_req | ~empty | flush_pend_q;
        fifo_level  = level_q;
        err_invalid = err_q;
        beat_cnt    = beat_cnt_q;
    end

    a_req_hold: assert property (@(posedge clk) disable iff (reset)
        (kp_req && !kp_ack) |=> (kp_req && $stable(k_ctrl)));

    a_level_bound: assert property (@(posedge clk) disable iff (reset)
        (level_q <= LEVEL_FULL));

endmodule

// File: tb/tb_iperm_kp_sched.sv
// Bench for iperm_kp_sched: vector table plus hand sequences, with a beat scoreboard on k_ctrl.
module tb_iperm_kp_sched;

    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_req;
    logic [3:0]    cmd_op;
    logic [CW-1:0] cmd_cnt;
    logic          cmd_ack;
    logic          kp_req;
    logic          kp_ack;
    logic [3:0]    k_ctrl;
    logic          flush;
    logic          flush_done;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic          err_invalid;
    logic          err_clr;
    logic [31:0]   beat_cnt;

    iperm_kp_sched #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_req     (cmd_req),
        .cmd_op      (cmd_op),
        .cmd_cnt     (cmd_cnt),
        .cmd_ack     (cmd_ack),
        .kp_req      (kp_req),
        .kp_ack      (kp_ack),
        .k_ctrl      (k_ctrl),
        .flush       (flush),
        .flush_done  (flush_done),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .err_invalid (err_invalid),
        .err_clr     (err_clr),
        .beat_cnt    (beat_cnt)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         req_cycles = 0;
    logic [3:0] exp_q[$];
    logic       hold_pend = 1'b0;
    logic [3:0] held_op = 4'd0;

    typedef struct {
        logic [3:0]    op;
        logic [CW-1:0] cnt;
        int            beats;
        logic          err;
        logic          clr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [CW-1:0] cnt);
        logic acc;
        bit   done;
        done    = 0;
        cmd_req = 1'b1;
        cmd_op  = op;
        cmd_cnt = cnt;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            acc = cmd_ack;
            step();
            if (acc) done = 1;
        end
        cmd_req = 1'b0;
        if (done) begin
            for (int i = 0; i < int'(cnt); i++) exp_q.push_back(op);
        end else begin
            chk("push_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_idle(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Beat monitor: scoreboard on every transfer, and hold check after every stall
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_req", 32'(kp_req), 32'd1);
                chk("hold_op", 32'(k_ctrl), 32'(held_op));
            end
            if (kp_req) req_cycles++;
            if (kp_req && kp_ack) begin
                if (exp_q.size() == 0) chk("sb_extra_beat", 32'd1, 32'd0);
                else chk("sb_op", 32'(k_ctrl), 32'(exp_q.pop_front()));
            end
            hold_pend = kp_req && !kp_ack;
            held_op   = k_ctrl;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b0;
        int          r0;
        bit          found;
        logic [3:0]  seq[4];

        vecs[0] = '{4'd3,  8'd1, 1, 1'b1, 1'b0};
        vecs[1] = '{4'd1,  8'd0, 0, 1'b1, 1'b0};
        vecs[2] = '{4'd5,  8'd2, 2, 1'b1, 1'b1};
        vecs[3] = '{4'd7,  8'd1, 1, 1'b0, 1'b0};
        vecs[4] = '{4'd0,  8'd3, 3, 1'b1, 1'b1};
        vecs[5] = '{4'd2,  8'd0, 0, 1'b1, 1'b1};
        vecs[6] = '{4'd1,  8'd5, 5, 1'b0, 1'b0};
        vecs[7] = '{4'd15, 8'd2, 2, 1'b1, 1'b0};
        seq[0] = 4'd1; seq[1] = 4'd1; seq[2] = 4'd7; seq[3] = 4'd7;

        reset = 1'b1; cmd_req = 1'b0; cmd_op = '0; cmd_cnt = '0;
        kp_ack = 1'b0; flush = 1'b0; err_clr = 1'b0;
        step();
        @(negedge clk);
        chk("rst_cmd_ack", 32'(cmd_ack), 32'd0);
        chk("rst_kp_req", 32'(kp_req), 32'd0);
        chk("rst_k_ctrl", 32'(k_ctrl), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_beat_cnt", beat_cnt, 32'd0);
        chk("rst_err", 32'(err_invalid), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;

        // Latency and single burst
        kp_ack = 1'b1;
        push_cmd(4'd5, 8'd3);
        @(negedge clk);
        chk("lat_pop_cycle_req", 32'(kp_req), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lat_req", 32'(kp_req), 32'd1);
            chk("lat_k_ctrl", 32'(k_ctrl), 32'd5);
            step();
        end
        @(negedge clk);
        chk("lat_req_end", 32'(kp_req), 32'd0);
        chk("lat_busy_end", 32'(busy), 32'd0);
        chk("lat_beat_cnt", beat_cnt, 32'd3);
        step();

        // Back-to-back chaining, then full-FIFO backpressure
        b0 = beat_cnt;
        push_cmd(4'd1, 8'd2);
        push_cmd(4'd7, 8'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_req", 32'(kp_req), 32'd1);
            chk("b2b_k_ctrl", 32'(k_ctrl), 32'(seq[i]));
            step();
        end
        @(negedge clk);
        chk("b2b_req_end", 32'(kp_req), 32'd0);
        step();
        kp_ack = 1'b0;
        push_cmd(4'd1, 8'd1);
        push_cmd(4'd5, 8'd1);
        push_cmd(4'd7, 8'd1);
        push_cmd(4'd1, 8'd2);
        push_cmd(4'd5, 8'd2);
        cmd_req = 1'b1; cmd_op = 4'd7; cmd_cnt = 8'd3;
        @(negedge clk);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_cmd_ack", 32'(cmd_ack), 32'd0);
        step();
        kp_ack = 1'b1;
        @(negedge clk);
        chk("full_pop_cmd_ack", 32'(cmd_ack), 32'd0);
        push_cmd(4'd7, 8'd3);
        wait_idle(200);
        chk("full_beats", beat_cnt - b0, 32'd14);
        step();

        // Stall mid-burst
        b0 = beat_cnt;
        push_cmd(4'd5, 8'd4);
        step();
        kp_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(kp_req), 32'd1);
            chk("stall_k_ctrl", 32'(k_ctrl), 32'd5);
            step();
        end
        kp_ack = 1'b1;
        wait_idle(100);
        chk("stall_beats", beat_cnt - b0, 32'd4);
        step();

        // Vector table: opcode validity, zero-count commands, sticky error
        for (int v = 0; v < 8; v++) begin
            b0 = beat_cnt;
            r0 = req_cycles;
            push_cmd(vecs[v].op, vecs[v].cnt);
            wait_idle(100);
            chk($sformatf("vec%0d_beats", v), beat_cnt - b0, 32'(vecs[v].beats));
            chk($sformatf("vec%0d_req_cycles", v), 32'(req_cycles - r0), 32'(vecs[v].beats));
            chk($sformatf("vec%0d_err", v), 32'(err_invalid), 32'(vecs[v].err));
            step();
            if (vecs[v].clr) begin
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                @(negedge clk);
                chk($sformatf("vec%0d_err_clr", v), 32'(err_invalid), 32'd0);
                step();
            end
        end

        // Set and clear in the same cycle: set wins
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        push_cmd(4'd4, 8'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_set_wins", 32'(err_invalid), 32'd1);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr_after", 32'(err_invalid), 32'd0);
        step();

        // Flush during a stalled burst
        b0 = beat_cnt;
        push_cmd(4'd1, 8'd10);
        push_cmd(4'd7, 8'd2);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (kp_req && kp_ack && (beat_cnt - b0 == 32'd2)) begin
                found = 1;
                break;
            end
        end
        if (!found) chk("fl_beat3_timeout", 32'd0, 32'd1);
        flush = 1'b1;
        chk("fl_level_pre", 32'(fifo_level), 32'd1);
        step();
        flush  = 1'b0;
        kp_ack = 1'b0;
        @(negedge clk);
        chk("fl_pend_cmd_ack", 32'(cmd_ack), 32'd0);
        chk("fl_pend_req", 32'(kp_req), 32'd1);
        step();
        @(negedge clk);
        chk("fl_not_done_yet", 32'(flush_done), 32'd0);
        step();
        kp_ack = 1'b1;
        @(negedge clk);
        chk("fl_apply_req", 32'(kp_req), 32'd1);
        chk("fl_apply_op", 32'(k_ctrl), 32'd1);
        step();
        @(negedge clk);
        chk("fl_done", 32'(flush_done), 32'd1);
        chk("fl_req_low", 32'(kp_req), 32'd0);
        chk("fl_level", 32'(fifo_level), 32'd0);
        chk("fl_beats", beat_cnt - b0, 32'd4);
        chk("fl_busy", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        chk("fl_done_pulse", 32'(flush_done), 32'd0);
        step();
        exp_q.delete();

        // Flush while idle
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fli_pend_busy", 32'(busy), 32'd1);
        chk("fli_done_early", 32'(flush_done), 32'd0);
        step();
        @(negedge clk);
        chk("fli_done", 32'(flush_done), 32'd1);
        step();

        // Reset in the middle of a burst with three queued commands
        kp_ack = 1'b0;
        push_cmd(4'd3, 8'd1);
        push_cmd(4'd1, 8'd1);
        push_cmd(4'd5, 8'd1);
        push_cmd(4'd7, 8'd1);
        @(negedge clk);
        chk("mr_level", 32'(fifo_level), 32'd3);
        chk("mr_req", 32'(kp_req), 32'd1);
        chk("mr_err", 32'(err_invalid), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mr_req_after", 32'(kp_req), 32'd0);
        chk("mr_level_after", 32'(fifo_level), 32'd0);
        chk("mr_beat_cnt_after", beat_cnt, 32'd0);
        chk("mr_err_after", 32'(err_invalid), 32'd0);
        chk("mr_busy_after", 32'(busy), 32'd0);
        exp_q.delete();
        step();

        kp_ack = 1'b1;
        push_cmd(4'd7, 8'd2);
        wait_idle(100);
        chk("post_rst_beats", beat_cnt, 32'd2);
        step();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
